// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered MIPS-datapath ALU.
// Holds the default datapath width, the 3-bit opcode type and the eight
// opcode encodings used by alu_comb, alu and their users.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t LOAD_A = 3'b000;
  localparam alu_op_t ADD    = 3'b001;
  localparam alu_op_t SUB    = 3'b010;
  localparam alu_op_t AND    = 3'b011;
  localparam alu_op_t INCREM = 3'b100;
  localparam alu_op_t NOT_A  = 3'b101;
  localparam alu_op_t XOR    = 3'b110;
  localparam alu_op_t LOAD_B = 3'b111;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational result, flag and signed-compare generator.
// Ports:
//   a, b          operands (two's complement)
//   alu_ctrl      operation select (alu_op_t)
//   result        truncated operation result
//   zero          result == 0
//   negative      result MSB
//   overflow      signed overflow of ADD / SUB / INCREM, 0 otherwise
//   equal_to      signed a == b (independent of alu_ctrl)
//   less_than     signed a <  b (independent of alu_ctrl)
//   greater_than  signed a >  b (independent of alu_ctrl)
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             equal_to,
  output logic             less_than,
  output logic             greater_than
);

  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_POS_C = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // Result mux and opcode-dependent signed overflow detection.
  always_comb begin
    result   = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (alu_ctrl)
      LOAD_A: result = a;
      ADD: begin
        result   = sum_s;
        // Same-sign operands whose sum flips sign.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        result   = diff_s;
        // Opposite-sign operands whose difference takes b's sign.
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      AND:    result = a & b;
      INCREM: begin
        result   = a + ONE_C;
        overflow = (a == MAX_POS_C);
      end
      NOT_A:  result = ~a;
      XOR:    result = a ^ b;
      LOAD_B: result = b;
      default: begin
        result   = {WIDTH{1'b0}};
        overflow = 1'b0;
      end
    endcase
  end

  assign zero     = (result == {WIDTH{1'b0}});
  assign negative = result[WIDTH-1];

  // Signed compare is always active so branch logic sees it for any opcode.
  assign equal_to     = ($signed(a) == $signed(b));
  assign less_than    = ($signed(a) <  $signed(b));
  assign greater_than = ($signed(a) >  $signed(b));

endmodule

// File: rtl/alu.sv
// alu: 32-bit registered arithmetic/logic unit with status flags.
// One cycle of latency: inputs sampled at rising edge N are visible after
// edge N and held until edge N+1. Asynchronous active-low reset clears the
// result and every flag (including zero and equal_to) to 0.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   a, b          operands (two's complement)
//   alu_ctrl      operation select
//   alu_out       registered result
//   zero, negative, overflow             registered result flags
//   equal_to, less_than, greater_than    registered signed compare of a, b
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          alu_ctrl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             equal_to,
  output logic             less_than,
  output logic             greater_than
);

  logic [WIDTH-1:0] result_s;
  logic             zero_s;
  logic             negative_s;
  logic             overflow_s;
  logic             equal_to_s;
  logic             less_than_s;
  logic             greater_than_s;

  logic [WIDTH-1:0] alu_out_r;
  logic             zero_r;
  logic             negative_r;
  logic             overflow_r;
  logic             equal_to_r;
  logic             less_than_r;
  logic             greater_than_r;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .a            (a),
    .b            (b),
    .alu_ctrl     (alu_ctrl),
    .result       (result_s),
    .zero         (zero_s),
    .negative     (negative_s),
    .overflow     (overflow_s),
    .equal_to     (equal_to_s),
    .less_than    (less_than_s),
    .greater_than (greater_than_s)
  );

  // Output register bank; reset values are constant 0, not derived from the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r      <= {WIDTH{1'b0}};
      zero_r         <= 1'b0;
      negative_r     <= 1'b0;
      overflow_r     <= 1'b0;
      equal_to_r     <= 1'b0;
      less_than_r    <= 1'b0;
      greater_than_r <= 1'b0;
    end else begin
      alu_out_r      <= result_s;
      zero_r         <= zero_s;
      negative_r     <= negative_s;
      overflow_r     <= overflow_s;
      equal_to_r     <= equal_to_s;
      less_than_r    <= less_than_s;
      greater_than_r <= greater_than_s;
    end
  end

  assign alu_out      = alu_out_r;
  assign zero         = zero_r;
  assign negative     = negative_r;
  assign overflow     = overflow_r;
  assign equal_to     = equal_to_r;
  assign less_than    = less_than_r;
  assign greater_than = greater_than_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Expected values come from a
// reference model that works on 64-bit signed integers and detects
// overflow by range, rather than by sign-bit rules.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero, negative, overflow, equal_to, less_than, greater_than;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .b            (b),
    .alu_ctrl     (alu_ctrl),
    .alu_out      (alu_out),
    .zero         (zero),
    .negative     (negative),
    .overflow     (overflow),
    .equal_to     (equal_to),
    .less_than    (less_than),
    .greater_than (greater_than)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // flags packed as {zero, negative, overflow, equal_to, less_than, greater_than}
  function automatic void model(input logic [2:0] op, input logic [31:0] va,
                                input logic [31:0] vb, output logic [31:0] r,
                                output logic [5:0] fl);
    longint la, lb, s, max_i, min_i;
    int     ia, ib;
    logic   ov;
    ia = va; ib = vb;
    la = ia; lb = ib;
    max_i = 64'sd2147483647;
    min_i = -64'sd2147483648;
    s  = 64'sd0;
    ov = 1'b0;
    case (op)
      LOAD_A: s = la;
      ADD:    begin s = la + lb; ov = (s > max_i) || (s < min_i); end
      SUB:    begin s = la - lb; ov = (s > max_i) || (s < min_i); end
      AND:    s = longint'(int'(va & vb));
      INCREM: begin s = la + 64'sd1; ov = (s > max_i); end
      NOT_A:  s = longint'(int'(~va));
      XOR:    s = longint'(int'(va ^ vb));
      default: s = lb;
    endcase
    r  = s[31:0];
    fl = {(r == 32'd0), r[31], ov, (la == lb), (la < lb), (la > lb)};
  endfunction

  task automatic check_now(input string tag, input logic [31:0] er, input logic [5:0] ef);
    chk({tag, ".out"}, alu_out, er);
    chk({tag, ".flags"},
        {26'd0, zero, negative, overflow, equal_to, less_than, greater_than},
        {26'd0, ef});
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] va, input logic [31:0] vb);
    logic [31:0] er;
    logic [5:0]  ef;
    @(negedge clk);
    alu_ctrl = op; a = va; b = vb;
    model(op, va, vb, er, ef);
    @(posedge clk);
    #1;
    check_now(tag, er, ef);
  endtask

  logic [2:0]  d_op [12];
  logic [31:0] d_a  [12];
  logic [31:0] d_b  [12];

  initial begin
    logic [31:0] er;
    logic [5:0]  ef;
    logic [31:0] ra, rb;

    // Reset held while clocking with nonzero inputs.
    rst_n = 1'b0; a = 32'h1234_5678; b = 32'h1234_5678; alu_ctrl = ADD;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset", 32'd0, 6'd0);

    // Release with ADD 10 + 15.
    @(negedge clk);
    rst_n = 1'b1; a = 32'd10; b = 32'd15; alu_ctrl = ADD;
    @(posedge clk);
    #1;
    chk("release.out", alu_out, 32'd25);
    chk("release.lt", {31'd0, less_than}, 32'd1);
    chk("release.ov", {31'd0, overflow}, 32'd0);

    // Directed boundary cases.
    d_op[0]  = ADD;    d_a[0]  = 32'd2000003300; d_b[0]  = 32'd1000000007;
    d_op[1]  = ADD;    d_a[1]  = 32'hFFFF_FFF8;  d_b[1]  = 32'd8;
    d_op[2]  = SUB;    d_a[2]  = 32'd1970;       d_b[2]  = 32'd1970;
    d_op[3]  = SUB;    d_a[3]  = 32'd0;          d_b[3]  = 32'h8000_0000;
    d_op[4]  = SUB;    d_a[4]  = 32'hFFFF_FFFF;  d_b[4]  = 32'h8000_0000;
    d_op[5]  = AND;    d_a[5]  = 32'd4;          d_b[5]  = 32'd7;
    d_op[6]  = AND;    d_a[6]  = 32'hFFFF_FFFF;  d_b[6]  = 32'hFFFF_FFF7;
    d_op[7]  = XOR;    d_a[7]  = 32'hDEAD_BEEF;  d_b[7]  = 32'hDEAD_BEEF;
    d_op[8]  = NOT_A;  d_a[8]  = 32'd0;          d_b[8]  = 32'd3;
    d_op[9]  = LOAD_B; d_a[9]  = 32'd9;          d_b[9]  = 32'd5;
    d_op[10] = INCREM; d_a[10] = 32'h7FFF_FFFF;  d_b[10] = 32'd1;
    d_op[11] = LOAD_A; d_a[11] = 32'h8000_0000;  d_b[11] = 32'd1;
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);
    end

    // Spot-check a few literal expectations independent of the model.
    run_op("sub_min", SUB, 32'd0, 32'h8000_0000);
    chk("sub_min.lit", alu_out, 32'h8000_0000);
    chk("sub_min.ov", {31'd0, overflow}, 32'd1);
    run_op("inc_max", INCREM, 32'h7FFF_FFFF, 32'd0);
    chk("inc_max.lit", alu_out, 32'h8000_0000);
    run_op("sub_m1", SUB, 32'hFFFF_FFFF, 32'h8000_0000);
    chk("sub_m1.lit", alu_out, 32'h7FFF_FFFF);
    chk("sub_m1.ov", {31'd0, overflow}, 32'd0);

    // Latency: mid-cycle input changes must not reach the outputs.
    run_op("lat0", ADD, 32'd1, 32'd2);
    alu_ctrl = SUB; a = 32'd100; b = 32'd1;
    #2;
    model(ADD, 32'd1, 32'd2, er, ef);
    check_now("lat.hold", er, ef);
    @(posedge clk);
    #1;
    model(SUB, 32'd100, 32'd1, er, ef);
    check_now("lat.next", er, ef);

    // Mid-cycle asynchronous reset discards the held result.
    run_op("pre_rst", XOR, 32'h0F0F_0F0F, 32'h00FF_00FF);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst", 32'd0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", SUB, 32'd7, 32'd9);

    // Randomized operations, biased towards equal operands and extremes.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h7FFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = 32'd0 - ra;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit registered arithmetic/logic unit for the MIPS datapath. It takes two signed 32-bit operands and a 3-bit operation code, and produces a result with status flags. All outputs are registered, with one cycle of latency. Downstream blocks (branch logic, writeback) consume the result and the flags.

## Interface
Parameters:
- WIDTH, 32, operand/result width; all rules below are stated for 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  32  operand A, two's complement
- b  input  32  operand B, two's complement
- alu_ctrl  input  3  operation select
- alu_out  output  32  registered result
- zero  output  1  registered; alu_out == 0
- negative  output  1  registered; alu_out[31]
- overflow  output  1  registered; signed overflow of the arithmetic op
- equal_to  output  1  registered; signed a == b
- less_than  output  1  registered; signed a < b
- greater_than  output  1  registered; signed a > b

## Operation
Opcodes, with result truncated to 32 bits:
- 000 LOAD_A: a
- 001 ADD: a + b
- 010 SUB: a − b
- 011 AND: a & b
- 100 INCREM: a + 1
- 101 NOT_A: ~a
- 110 XOR: a ^ b
- 111 LOAD_B: b

Flags, all computed from the same-cycle inputs and the unregistered result:
- zero = (result == 0), for every opcode.
- negative = result[31], for every opcode.
- overflow:
  - ADD: a[31]==b[31] and result[31]!=a[31].
  - SUB: a[31]!=b[31] and result[31]!=a[31].
  - INCREM: a == 32'h7FFF_FFFF.
  - All other opcodes: 0.
- equal_to, less_than and greater_than form a signed comparison of a against b. They are evaluated for every opcode, independent of alu_ctrl. Exactly one of the three is 1 at any time after the first post-reset edge.
- No carry output; unsigned carry-out is discarded.

## Timing
- Reset:
  - Asserting rst_n=0 immediately clears alu_out and all six flags to 0, regardless of clk.
  - This includes zero=0 and equal_to=0; reset values are not derived from the result.
  - Release is synchronous in effect: the first rising clk edge with rst_n=1 loads real values.
- Latency: inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1. Throughput is one operation per cycle; there is no handshake and no stall.
- Changing alu_ctrl, a or b mid-cycle has no effect on the outputs until the next edge.
- Reset asserted mid-stream discards the in-flight result. The first edge after release reflects the inputs present at that edge.

## Structure
- Package alu_pkg holds:
  - the eight opcode localparams (LOAD_A, ADD, SUB, AND, INCREM, NOT_A, XOR, LOAD_B);
  - a typedef for the 3-bit opcode;
  - the WIDTH default.
- One sub-module, alu_comb: a purely combinational result, flag and compare generator.
- Top-level alu instantiates alu_comb and owns the output register bank with asynchronous reset.

## Test plan
- Reset: hold rst_n=0 while clk toggles with nonzero inputs -> all outputs 0. Release with ADD, a=10, b=15 -> next edge gives alu_out=25, less_than=1, overflow=0.
- ADD overflow: a=2000003300, b=1000000007 -> alu_out=32'hB2D05EEB, negative=1, overflow=1, greater_than=1.
- ADD cancelling: a=−8, b=8 -> alu_out=0, zero=1, less_than=1, overflow=0.
- SUB:
  - a=1970, b=1970 -> zero=1, equal_to=1.
  - a=0, b=32'h8000_0000 -> alu_out=32'h8000_0000, overflow=1, negative=1, greater_than=1.
  - a=−1, b=32'h8000_0000 -> alu_out=32'h7FFF_FFFF, overflow=0.
- Logic and load ops:
  - AND a=4, b=7 -> 4.
  - AND a=−1, b=−9 -> 32'hFFFF_FFF7, negative=1.
  - XOR a=b -> zero=1.
  - NOT_A a=0 -> 32'hFFFF_FFFF.
  - LOAD_B b=5 -> 5.
  - INCREM a=32'h7FFF_FFFF -> 32'h8000_0000, overflow=1.
- Latency check: change inputs between edges -> outputs change only at the next rising edge, exactly one cycle later.
